// File: rtl/game_sequencer.sv
// game_sequencer -- frame-level controller for ROBO-ESCAPE.
//
// Owns the pixel scan counters, produces frame-synchronised move strobes for
// the character and projectile logic, and runs the life / death / respawn /
// game-over state machine.
//
// Optional feature macro: SPAWN_GUARD_EN
//   When defined, projectile and trap hits are ignored for GUARD_FRAMES frames
//   after each respawn (the manual kill button still kills). When undefined,
//   every hit source is honoured from the first PLAY cycle.
//
// Ports:
//   clock            in   system clock, all logic on posedge
//   reset            in   synchronous, active-high
//   key_start_n      in   active-low start/restart button (already synchronised)
//   key_die_n        in   active-low manual kill button
//   hit_projectile   in   character/projectile overlap this cycle
//   hit_trap         in   character/trap overlap this cycle
//   x_cord[8:0]      out  scan x
//   y_cord[8:0]      out  scan y
//   frame_tick       out  high while the scan sits on the last pixel of a frame
//   character_step   out  one-cycle move enable for the character logic
//   projectile_step  out  one-cycle move enable for the projectile logic
//   respawn          out  one-cycle pulse: reload start positions
//   lives[2:0]       out  remaining lives
//   state[2:0]       out  IDLE=0, PLAY=1, DYING=2, RESPAWN=3, OVER=4
//   game_over        out  high while in OVER
module game_sequencer #(
  parameter int MAX_X        = 319,
  parameter int MAX_Y        = 239,
  parameter int CHAR_DIV     = 1,
  parameter int PROJ_DIV     = 2,
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 30,
  parameter int GUARD_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_die_n,
  input  logic       hit_projectile,
  input  logic       hit_trap,
  output logic [8:0] x_cord,
  output logic [8:0] y_cord,
  output logic       frame_tick,
  output logic       character_step,
  output logic       projectile_step,
  output logic       respawn,
  output logic [2:0] lives,
  output logic [2:0] state,
  output logic       game_over
);

  localparam logic [2:0] STATE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_PLAY    = 3'd1;
  localparam logic [2:0] STATE_DYING   = 3'd2;
  localparam logic [2:0] STATE_RESPAWN = 3'd3;
  localparam logic [2:0] STATE_OVER    = 3'd4;

  localparam logic [8:0] X_LAST      = 9'(MAX_X);
  localparam logic [8:0] Y_LAST      = 9'(MAX_Y);
  localparam logic [3:0] CHAR_LAST   = 4'(CHAR_DIV - 1);
  localparam logic [3:0] PROJ_LAST   = 4'(PROJ_DIV - 1);
  localparam logic [2:0] LIVES_INIT  = 3'(LIVES);
  localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);

  logic [3:0] char_cnt;
  logic [3:0] proj_cnt;
  logic [7:0] death_cnt;
  logic       hit;
  logic       in_play;

  // Scan counters: free-running in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_cord <= '0;
      y_cord <= '0;
    end else if (x_cord == X_LAST) begin
      x_cord <= '0;
      y_cord <= (y_cord == Y_LAST) ? 9'd0 : y_cord + 9'd1;
    end else begin
      x_cord <= x_cord + 9'd1;
    end
  end

  assign frame_tick = (x_cord == X_LAST) && (y_cord == Y_LAST);
  assign in_play    = (state == STATE_PLAY);

`ifdef SPAWN_GUARD_EN
  localparam logic [7:0] GUARD_INIT = 8'(GUARD_FRAMES);
  logic [7:0] guard_cnt;

  // Guard loads while in RESPAWN and drains one step per frame during PLAY.
  always_ff @(posedge clock) begin
    if (reset) begin
      guard_cnt <= '0;
    end else if (state == STATE_RESPAWN) begin
      guard_cnt <= GUARD_INIT;
    end else if (in_play && frame_tick && (guard_cnt != 8'd0)) begin
      guard_cnt <= guard_cnt - 8'd1;
    end
  end

  // The manual kill button bypasses the guard.
  assign hit = ((hit_projectile | hit_trap) & (guard_cnt == 8'd0)) | ~key_die_n;
`else
  assign hit = hit_projectile | hit_trap | ~key_die_n;
`endif

  // A hit on a frame_tick cycle takes priority, so no step leaves that cycle.
  assign character_step  = in_play && frame_tick && !hit && (char_cnt == CHAR_LAST);
  assign projectile_step = in_play && frame_tick && !hit && (proj_cnt == PROJ_LAST);
  assign respawn         = (state == STATE_RESPAWN);
  assign game_over       = (state == STATE_OVER);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= STATE_IDLE;
      lives     <= LIVES_INIT;
      char_cnt  <= '0;
      proj_cnt  <= '0;
      death_cnt <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (!key_start_n) begin
            state <= STATE_RESPAWN;
            lives <= LIVES_INIT;
          end
        end

        STATE_RESPAWN: begin
          state    <= STATE_PLAY;
          char_cnt <= '0;
          proj_cnt <= '0;
        end

        STATE_PLAY: begin
          if (hit) begin
            state     <= STATE_DYING;
            death_cnt <= '0;
            if (lives != 3'd0) begin
              lives <= lives - 3'd1;
            end
          end else if (frame_tick) begin
            char_cnt <= (char_cnt == CHAR_LAST) ? 4'd0 : char_cnt + 4'd1;
            proj_cnt <= (proj_cnt == PROJ_LAST) ? 4'd0 : proj_cnt + 4'd1;
          end
        end

        STATE_DYING: begin
          if (frame_tick) begin
            if (death_cnt == DEATH_LAST) begin
              death_cnt <= '0;
              state     <= (lives == 3'd0) ? STATE_OVER : STATE_RESPAWN;
            end else begin
              death_cnt <= death_cnt + 8'd1;
            end
          end
        end

        STATE_OVER: begin
          if (!key_start_n) begin
            state <= STATE_IDLE;
          end
        end

        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer with a 4x3 scan (12 cycles per frame).
module tb_game_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_start_n;
  logic       key_die_n;
  logic       hit_projectile;
  logic       hit_trap;
  logic [8:0] x_cord;
  logic [8:0] y_cord;
  logic       frame_tick;
  logic       character_step;
  logic       projectile_step;
  logic       respawn;
  logic [2:0] lives;
  logic [2:0] state;
  logic       game_over;

  localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_RESPAWN = 3, S_OVER = 4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // cycles since the last reset edge; scan position = cyc % 12

  game_sequencer #(
    .MAX_X(3), .MAX_Y(2), .CHAR_DIV(1), .PROJ_DIV(2),
    .LIVES(2), .DEATH_FRAMES(2), .GUARD_FRAMES(2)
  ) dut (
    .clock(clock), .reset(reset), .key_start_n(key_start_n), .key_die_n(key_die_n),
    .hit_projectile(hit_projectile), .hit_trap(hit_trap),
    .x_cord(x_cord), .y_cord(y_cord), .frame_tick(frame_tick),
    .character_step(character_step), .projectile_step(projectile_step),
    .respawn(respawn), .lives(lives), .state(state), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle();
    logic r;
    r = reset;
    @(posedge clock);
    #1;
    if (r) cyc = 0;
    else   cyc++;
  endtask

  // Advance to the sample point of the next last-pixel cycle.
  task automatic run_to_tick();
    do cycle(); while ((cyc % 12) != 11);
  endtask

  // With the guard compiled in, let it drain before relying on trap/projectile hits.
  task automatic settle_guard();
`ifdef SPAWN_GUARD_EN
    run_to_tick();
    run_to_tick();
    cycle();
`endif
  endtask

  task automatic dying_to_respawn(input string tag);
    run_to_tick();
    check({tag, "_dying_t1"}, state, S_DYING);
    check({tag, "_dying_steps"}, {character_step, projectile_step}, 0);
    run_to_tick();
    check({tag, "_dying_t2"}, state, S_DYING);
    cycle();
  endtask

  initial begin
    int p;
    int ft_seen;
    int k;
    int n_char;
    int n_proj;

    reset = 1'b1; key_start_n = 1'b1; key_die_n = 1'b1;
    hit_projectile = 1'b0; hit_trap = 1'b0;
    cycle();
    cycle();
    check("rst_x", x_cord, 0);
    check("rst_y", y_cord, 0);
    check("rst_state", state, S_IDLE);
    check("rst_lives", lives, 2);
    check("rst_pulses", {frame_tick, character_step, projectile_step, respawn, game_over}, 0);
    reset = 1'b0;

    // 1. Free-running scan in IDLE.
    ft_seen = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      p = cyc % 12;
      check("scan_x", x_cord, p % 4);
      check("scan_y", y_cord, p / 4);
      check("scan_tick", frame_tick, (p == 11) ? 1 : 0);
      check("idle_state", state, S_IDLE);
      check("idle_pulses", {character_step, projectile_step, respawn}, 0);
      if (frame_tick) ft_seen++;
    end
    check("scan_tick_count", ft_seen, 2);

    // 2. Start: RESPAWN for one cycle, then PLAY with steps.
    key_start_n = 1'b0;
    cycle();
    key_start_n = 1'b1;
    check("start_state", state, S_RESPAWN);
    check("start_lives", lives, 2);
    check("start_respawn", respawn, 1);
    cycle();
    check("play_state", state, S_PLAY);
    check("play_respawn_low", respawn, 0);
    k = 0; n_char = 0; n_proj = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      if (character_step) n_char++;
      if (projectile_step) n_proj++;
      if ((cyc % 12) == 11) begin
        k++;
        check("char_step_tick", character_step, 1);
        check("proj_step_tick", projectile_step, (k % 2 == 0) ? 1 : 0);
      end else begin
        check("steps_off_tick", {character_step, projectile_step}, 0);
      end
    end
    check("char_step_total", n_char, 4);
    check("proj_step_total", n_proj, 2);
    check("play_state_held", state, S_PLAY);

    // 3. Trap hit: DYING, lives 1, extra hits ignored, respawn after 2 frames.
    hit_trap = 1'b1;
    cycle();
    hit_trap = 1'b0;
    check("trap_state", state, S_DYING);
    check("trap_lives", lives, 1);
    hit_projectile = 1'b1;
    cycle();
    hit_projectile = 1'b0;
    check("dying_hit_ignored_lives", lives, 1);
    check("dying_hit_ignored_state", state, S_DYING);
    dying_to_respawn("t3");
    check("t3_respawn_state", state, S_RESPAWN);
    check("t3_respawn_pulse", respawn, 1);
    cycle();
    check("t3_play", state, S_PLAY);
    check("t3_respawn_low", respawn, 0);

    // 4. Last life lost: OVER, then restart with start held low.
    settle_guard();
    hit_projectile = 1'b1;
    cycle();
    hit_projectile = 1'b0;
    check("proj_state", state, S_DYING);
    check("proj_lives", lives, 0);
    dying_to_respawn("t4");
    check("over_state", state, S_OVER);
    check("over_flag", game_over, 1);
    check("over_no_respawn", respawn, 0);
    cycle();
    cycle();
    check("over_held", state, S_OVER);
    key_start_n = 1'b0;
    cycle();
    check("over_to_idle", state, S_IDLE);
    check("idle_flag_low", game_over, 0);
    check("idle_lives_not_reloaded", lives, 0);
    cycle();
    key_start_n = 1'b1;
    check("held_start_respawn", state, S_RESPAWN);
    check("reload_lives", lives, 2);
    cycle();
    check("restart_play", state, S_PLAY);

    // Manual kill button.
    key_die_n = 1'b0;
    cycle();
    key_die_n = 1'b1;
    check("die_key_state", state, S_DYING);
    check("die_key_lives", lives, 1);
    dying_to_respawn("kill");
    check("kill_respawn", state, S_RESPAWN);
    cycle();
    check("kill_play", state, S_PLAY);

    // 5. Hit on the frame_tick cycle: no step, DYING wins.
    settle_guard();
    run_to_tick();
    check("t5_state", state, S_PLAY);
    hit_trap = 1'b1;
    #1;
    check("t5_tick", frame_tick, 1);
    check("t5_no_char_step", character_step, 0);
    check("t5_no_proj_step", projectile_step, 0);
    cycle();
    hit_trap = 1'b0;
    check("t5_dying", state, S_DYING);
    check("t5_lives", lives, 0);

    // Reset while DYING.
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("dying_reset_state", state, S_IDLE);
    check("dying_reset_lives", lives, 2);
    check("dying_reset_xy", {x_cord, y_cord}, 0);

    // 6. Trap held high across RESPAWN.
    cycle();
    key_start_n = 1'b0;
    cycle();
    key_start_n = 1'b1;
    hit_trap = 1'b1;
    check("t6_respawn", state, S_RESPAWN);
    cycle();
    check("t6_play", state, S_PLAY);
`ifdef SPAWN_GUARD_EN
    run_to_tick();
    check("t6_guard_t1", state, S_PLAY);
    run_to_tick();
    check("t6_guard_t2", state, S_PLAY);
    check("t6_guard_step", character_step, 1);
    cycle();
    check("t6_guard_expired", state, S_PLAY);
    cycle();
    check("t6_guard_dying", state, S_DYING);
`else
    cycle();
    check("t6_dying", state, S_DYING);
`endif
    check("t6_lives", lives, 1);
    hit_trap = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
